// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and datapath widths.
package loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte idle timer: down-counter reloaded on clear, expires at terminal count zero.
module loader_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else if (clear) begin
      cnt_q <= LOAD_VAL;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words into instruction RAM, holds CPU in reset.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  IDLE     | out of reset, nothing loaded yet
//  LEN      | waiting for word-count byte (0 means 256)
//  HI       | waiting for high byte of next word
//  LO       | waiting for low byte of next word
//  WRITE    | one-cycle RAM write strobe, advance address/count
//  CSUM     | waiting for checksum byte (checksum build only)
//  DONE     | load complete, CPU released
//  ERR      | load aborted (timeout or bad checksum), CPU held
module program_loader
  import loader_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADR = '0,
  parameter int                 TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [BYTE_W-1:0]     rx_data,
  output logic                  rx_ready,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_adr,
  output logic [WORD_W-1:0]     ram_wdata,
  output logic                  cpu_reset_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   hi_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   adr_q;
  logic                accept;
  logic                accept_ok;
  logic                start_ok;
  logic                expired;
  logic                last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   sum_q;
`endif

  assign rx_ready  = (state_q == ST_LEN) || (state_q == ST_HI) ||
                     (state_q == ST_LO)  || (state_q == ST_CSUM);
  assign accept    = rx_valid && rx_ready;
  // A byte arriving in the same cycle the timer expires is discarded.
  assign accept_ok = accept && !expired;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
  assign last_word = (cnt_q == CNT_W'(1));

  loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_ok || start_ok),
    .enable  (rx_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ram_we         = 1'b0;
    busy           = 1'b0;
    cpu_reset_hold = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN, ST_HI, ST_LO: begin
        busy           = 1'b1;
        cpu_reset_hold = 1'b1;
        if (expired) begin
          state_d = ST_ERR;
        end else if (accept) begin
          if (state_q == ST_LEN)     state_d = ST_HI;
          else if (state_q == ST_HI) state_d = ST_LO;
          else                       state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_we         = 1'b1;
        busy           = 1'b1;
        cpu_reset_hold = 1'b1;
        if (!last_word) begin
          state_d = ST_HI;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_CSUM: begin
        busy           = 1'b1;
        cpu_reset_hold = 1'b1;
        if (expired) begin
          state_d = ST_ERR;
        end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
`else
          state_d = ST_ERR;
`endif
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_LEN;
      end
      ST_ERR: begin
        error          = 1'b1;
        cpu_reset_hold = 1'b1;
        if (start) state_d = ST_LEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      adr_q   <= BASE_ADR;
    end else begin
      if (start_ok) begin
        adr_q <= BASE_ADR;
      end
      if (accept_ok) begin
        case (state_q)
          ST_LEN:  cnt_q   <= (rx_data == '0) ? CNT_W'(256) : CNT_W'(rx_data);
          ST_HI:   hi_q    <= rx_data;
          ST_LO:   wdata_q <= {hi_q, rx_data};
          default: ;
        endcase
      end
      if (state_q == ST_WRITE) begin
        adr_q <= adr_q + 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (accept_ok && ((state_q == ST_HI) || (state_q == ST_LO))) begin
      sum_q <= sum_q + rx_data;
    end
  end
`endif

  assign ram_adr   = adr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes queued at stimulus, checked on ram_we.
module tb_program_loader;

  localparam int          ADDR_W  = 8;
  localparam logic [7:0]  BASE    = 8'h10;
  localparam int          TO      = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, ram_we, cpu_reset_hold, busy, done, error;
  logic [7:0]  ram_adr;
  logic [15:0] ram_wdata;

  int          n_cmp = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  logic [7:0]  last_adr = 8'h00;
  logic [23:0] exp_q[$];

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADR(BASE), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .ram_we         (ram_we),
    .ram_adr        (ram_adr),
    .ram_wdata      (ram_wdata),
    .cpu_reset_hold (cpu_reset_hold),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we) begin
      logic [23:0] e;
      we_cnt++;
      last_adr = ram_adr;
      if (exp_q.size() == 0) begin
        chk("unexp_we", ram_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("we_adr", ram_adr, e[23:16]);
        chk("we_data", ram_wdata, e[15:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (rx_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rx_ready"}, rx_ready, 1'b0);
    chk({pfx, "_ram_we"}, ram_we, 1'b0);
    chk({pfx, "_busy"}, busy, 1'b0);
    chk({pfx, "_done"}, done, 1'b0);
    chk({pfx, "_error"}, error, 1'b0);
    chk({pfx, "_hold"}, cpu_reset_hold, 1'b0);
    chk({pfx, "_adr"}, ram_adr, BASE);
    chk({pfx, "_wdata"}, ram_wdata, 16'h0000);
  endtask

  // Test-1 style load: 02 12 34 AB CD (+checksum BE); gap > 0 adds idle cycles between bytes.
  task automatic load_two_words(input bit mid_start, input bit gaps);
    logic [7:0] bytes [5];
    bytes[0] = 8'h02; bytes[1] = 8'h12; bytes[2] = 8'h34; bytes[3] = 8'hAB; bytes[4] = 8'hCD;
    exp_q.push_back({BASE, 16'h1234});
    exp_q.push_back({BASE + 8'd1, 16'hABCD});
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_hold", cpu_reset_hold, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], gaps ? int'($urandom_range(0, 4)) : 0);
      if (mid_start && i == 2) begin
        pulse_start();
        chk("t6_busy_kept", busy, 1'b1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hBE, 0);
`endif
    wait_end(100);
    chk("t1_done", done, 1'b1);
    chk("t1_error", error, 1'b0);
    chk("t1_hold_rel", cpu_reset_hold, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    logic [7:0] sum;
    logic [7:0] h, l;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Test 1: basic two-word load
    we_cnt = 0;
    load_two_words(1'b0, 1'b0);
    chk("t1_we_cnt", we_cnt, 2);

    // Test 2: N=0 -> 256 words, address wraps to BASE-1
    we_cnt = 0;
    sum = 8'h00;
    pulse_start();
    chk("t2_adr_base", ram_adr, BASE);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      h = 8'($urandom);
      l = 8'($urandom);
      sum = sum + h + l;
      exp_q.push_back({BASE + 8'(i), h, l});
      send_byte(h, 0);
      send_byte(l, 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum, 0);
`endif
    wait_end(100);
    chk("t2_done", done, 1'b1);
    chk("t2_we_cnt", we_cnt, 256);
    chk("t2_last_adr", last_adr, BASE - 8'd1);
    chk("t2_q_empty", exp_q.size(), 0);

    // Test 3: timeout after 01 12, no write
    we_cnt = 0;
    pulse_start();
    chk("t3_done_clr", done, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    cyc = 0;
    for (int i = 0; i < TO + 20; i++) begin
      @(negedge clk);
      cyc++;
      if (error) break;
    end
    chk("t3_error", error, 1'b1);
    chk("t3_hold", cpu_reset_hold, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_window", (cyc >= TO) && (cyc <= TO + 4), 1'b1);
    chk("t3_we_cnt", we_cnt, 0);

    // Test 4: single word, checksum good then bad
    we_cnt = 0;
    exp_q.push_back({BASE, 16'h1234});
    pulse_start();
    chk("t4_err_clr", error, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h46, 0);
`endif
    wait_end(100);
    chk("t4_done", done, 1'b1);
    chk("t4_hold", cpu_reset_hold, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back({BASE, 16'h1234});
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h47, 0);
    wait_end(100);
    chk("t4_bad_error", error, 1'b1);
    chk("t4_bad_hold", cpu_reset_hold, 1'b1);
    chk("t4_we_cnt", we_cnt, 2);
`else
    chk("t4_we_cnt", we_cnt, 1);
`endif
    chk("t4_q_empty", exp_q.size(), 0);

    // Test 6: start mid-load ignored, gaps and backpressure
    we_cnt = 0;
    load_two_words(1'b1, 1'b1);
    chk("t6_we_cnt", we_cnt, 2);

    // Test 5: reset between HI and LO bytes
    we_cnt = 0;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("t5_in");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_vals("t5_after");
    chk("t5_we_cnt", we_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
